// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage core: load-use interlock, taken-branch
// flush, and multdiv occupancy of X with its start/ready handshake and timeout abort.
module hazard_stall_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] fd_insn,
  input  logic [31:0] dx_insn,
  input  logic        branch_taken,
  input  logic        multdiv_ready,
  output logic        stall_pc,
  output logic        stall_fd,
  output logic        stall_dx,
  output logic        bubble_xm,
  output logic        bubble_dx,
  output logic        flush_fd,
  output logic        md_start_mult,
  output logic        md_start_div,
  output logic        md_result_valid,
  output logic        md_busy,
  output logic        md_timeout
);

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_BEQ  = 5'b01001;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MD_TIMEOUT);

  typedef enum logic {IDLE, MD_WAIT} state_t;

  function automatic logic is_branch(input logic [4:0] op);
    return (op == OP_BNE) || (op == OP_BLT) || (op == OP_BEQ);
  endfunction

  function automatic logic reads_rs(input logic [4:0] op);
    return (op == OP_R) || (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW) ||
           is_branch(op);
  endfunction

  // Shift aluops 0010x carry shamt instead of rt.
  function automatic logic reads_rt(input logic [4:0] op, input logic [4:0] aluop);
    return (op == OP_R) && (aluop[4:1] != 4'b0010);
  endfunction

  function automatic logic reads_rd(input logic [4:0] op);
    return is_branch(op) || (op == OP_JR);
  endfunction

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt, fd_aluop;
  logic [4:0] dx_op, dx_rd, dx_aluop;
  logic       unused_insn_bits;

  assign fd_op    = fd_insn[31:27];
  assign fd_rd    = fd_insn[26:22];
  assign fd_rs    = fd_insn[21:17];
  assign fd_rt    = fd_insn[16:12];
  assign fd_aluop = fd_insn[6:2];
  assign dx_op    = dx_insn[31:27];
  assign dx_rd    = dx_insn[26:22];
  assign dx_aluop = dx_insn[6:2];
  assign unused_insn_bits = ^{fd_insn[11:7], fd_insn[1:0], dx_insn[21:7], dx_insn[1:0]};

  logic dx_is_lw, dx_is_mul, dx_is_div, load_use;

  assign dx_is_lw  = (dx_op == OP_LW) && (dx_rd != 5'd0);
  assign dx_is_mul = (dx_op == OP_R) && (dx_aluop == ALU_MUL);
  assign dx_is_div = (dx_op == OP_R) && (dx_aluop == ALU_DIV);

  // An sw matching only on rd is left to the WM bypass; rd use is limited to branches/jr.
  assign load_use = dx_is_lw &&
                    ((reads_rs(fd_op) && (fd_rs == dx_rd)) ||
                     (reads_rt(fd_op, fd_aluop) && (fd_rt == dx_rd)) ||
                     (reads_rd(fd_op) && (fd_rd == dx_rd)));

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             timeout_q, timeout_nxt;

  logic stall_pc_c, stall_fd_c, stall_dx_c, bubble_xm_c, bubble_dx_c, flush_fd_c;
  logic start_mult_c, start_div_c, result_valid_c;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    timeout_nxt    = timeout_q;
    stall_pc_c     = 1'b0;
    stall_fd_c     = 1'b0;
    stall_dx_c     = 1'b0;
    bubble_xm_c    = 1'b0;
    bubble_dx_c    = 1'b0;
    flush_fd_c     = 1'b0;
    start_mult_c   = 1'b0;
    start_div_c    = 1'b0;
    result_valid_c = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (branch_taken) begin
          flush_fd_c  = 1'b1;
          bubble_dx_c = 1'b1;
        end else if (dx_is_mul || dx_is_div) begin
          start_mult_c = dx_is_mul;
          start_div_c  = dx_is_div;
          stall_pc_c   = 1'b1;
          stall_fd_c   = 1'b1;
          stall_dx_c   = 1'b1;
          bubble_xm_c  = 1'b1;
          state_nxt    = MD_WAIT;
        end else if (load_use) begin
          stall_pc_c  = 1'b1;
          stall_fd_c  = 1'b1;
          bubble_dx_c = 1'b1;
        end
      end
      MD_WAIT: begin
        // Releasing the stalls in the result cycle lets the mul/div advance into XM.
        if (multdiv_ready) begin
          result_valid_c = 1'b1;
          cnt_nxt        = '0;
          state_nxt      = IDLE;
        end else if (cnt == TIMEOUT_CNT) begin
          result_valid_c = 1'b1;
          timeout_nxt    = 1'b1;
          cnt_nxt        = '0;
          state_nxt      = IDLE;
        end else begin
          stall_pc_c  = 1'b1;
          stall_fd_c  = 1'b1;
          stall_dx_c  = 1'b1;
          bubble_xm_c = 1'b1;
          cnt_nxt     = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Combinational outputs are forced low while reset is held.
  assign stall_pc        = reset_n & stall_pc_c;
  assign stall_fd        = reset_n & stall_fd_c;
  assign stall_dx        = reset_n & stall_dx_c;
  assign bubble_xm       = reset_n & bubble_xm_c;
  assign bubble_dx       = reset_n & bubble_dx_c;
  assign flush_fd        = reset_n & flush_fd_c;
  assign md_start_mult   = reset_n & start_mult_c;
  assign md_start_div    = reset_n & start_div_c;
  assign md_result_valid = reset_n & result_valid_c;
  assign md_busy         = (state == MD_WAIT);
  assign md_timeout      = timeout_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scenario bench for hazard_stall_ctrl: per-cycle expected output vectors are queued
// when stimulus is driven and compared at the following falling edge.
module tb_hazard_stall_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] fd_insn, dx_insn;
  logic        branch_taken, multdiv_ready;
  logic        stall_pc, stall_fd, stall_dx, bubble_xm, bubble_dx, flush_fd;
  logic        md_start_mult, md_start_div, md_result_valid, md_busy, md_timeout;

  hazard_stall_ctrl #(.MD_TIMEOUT(40), .CNT_W(6)) dut (
    .clock(clock), .reset_n(reset_n), .fd_insn(fd_insn), .dx_insn(dx_insn),
    .branch_taken(branch_taken), .multdiv_ready(multdiv_ready),
    .stall_pc(stall_pc), .stall_fd(stall_fd), .stall_dx(stall_dx),
    .bubble_xm(bubble_xm), .bubble_dx(bubble_dx), .flush_fd(flush_fd),
    .md_start_mult(md_start_mult), .md_start_div(md_start_div),
    .md_result_valid(md_result_valid), .md_busy(md_busy), .md_timeout(md_timeout)
  );

  always #5 clock = ~clock;

  // Bit order: stall_pc stall_fd stall_dx bubble_xm bubble_dx flush_fd
  //            start_mult start_div result_valid busy timeout
  logic [10:0] obs;
  assign obs = {stall_pc, stall_fd, stall_dx, bubble_xm, bubble_dx, flush_fd,
                md_start_mult, md_start_div, md_result_valid, md_busy, md_timeout};

  localparam logic [10:0] Z     = 11'b00000000000;
  localparam logic [10:0] LU    = 11'b11001000000;
  localparam logic [10:0] FL    = 11'b00001100000;
  localparam logic [10:0] S_MUL = 11'b11110010000;
  localparam logic [10:0] S_DIV = 11'b11110001000;
  localparam logic [10:0] WT    = 11'b11110000010;
  localparam logic [10:0] DONE  = 11'b00000000110;
  localparam logic [10:0] TO    = 11'b00000000001;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];
  logic [10:0] want;

  function automatic logic [31:0] r_ins(input logic [4:0] rd, rs, rt, aluop);
    return {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] i_ins(input logic [4:0] op, rd, rs);
    return {op, rd, rs, 17'd4};
  endfunction

  logic [31:0] nop, lw5, lw0, mul_i, div_i, add_dep;
  initial begin
    nop     = 32'd0;
    lw5     = i_ins(5'b01000, 5'd5, 5'd1);
    lw0     = i_ins(5'b01000, 5'd0, 5'd1);
    mul_i   = r_ins(5'd3, 5'd1, 5'd2, 5'b00110);
    div_i   = r_ins(5'd4, 5'd1, 5'd2, 5'b00111);
    add_dep = r_ins(5'd6, 5'd5, 5'd7, 5'b00000);
  end

  task automatic drive(input logic [31:0] fd, dx, input logic bt, rdy, input logic [10:0] e);
    @(posedge clock);
    #1;
    fd_insn = fd; dx_insn = dx; branch_taken = bt; multdiv_ready = rdy;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    fd_insn = add_dep; dx_insn = lw5; branch_taken = 1'b1; multdiv_ready = 1'b1;
    #3;
    exp_q.push_back(Z);
    want = exp_q.pop_front();
    checks++;
    if (obs !== want) begin errors++; $display("FAIL reset_hold: got %b want %b", obs, want); end
    dx_insn = mul_i; branch_taken = 1'b0;
    #1;
    exp_q.push_back(Z);
    want = exp_q.pop_front();
    checks++;
    if (obs !== want) begin errors++; $display("FAIL reset_mul: got %b want %b", obs, want); end
    @(negedge clock);
    fd_insn = nop; dx_insn = nop; multdiv_ready = 1'b0;
    reset_n = 1'b1;
    drive(nop, nop, 1'b0, 1'b0, Z);
    @(negedge clock);
    want = exp_q.pop_front();
    checks++;
    if (obs !== want) begin errors++; $display("FAIL reset_release: got %b want %b", obs, want); end
  endtask

  task automatic test_load_use();
    logic [31:0] fds[11], dxs[11];
    logic [10:0] es[11];
    fds[0]  = add_dep;                              dxs[0]  = lw5; es[0]  = LU;
    fds[1]  = i_ins(5'b00111, 5'd5, 5'd9);          dxs[1]  = lw5; es[1]  = Z;
    fds[2]  = r_ins(5'd6, 5'd0, 5'd7, 5'b00000);    dxs[2]  = lw0; es[2]  = Z;
    fds[3]  = r_ins(5'd6, 5'd7, 5'd5, 5'b00000);    dxs[3]  = lw5; es[3]  = LU;
    fds[4]  = r_ins(5'd6, 5'd7, 5'd5, 5'b00100);    dxs[4]  = lw5; es[4]  = Z;
    fds[5]  = i_ins(5'b00010, 5'd5, 5'd7);          dxs[5]  = lw5; es[5]  = LU;
    fds[6]  = i_ins(5'b00100, 5'd5, 5'd0);          dxs[6]  = lw5; es[6]  = LU;
    fds[7]  = i_ins(5'b00111, 5'd6, 5'd5);          dxs[7]  = lw5; es[7]  = LU;
    fds[8]  = add_dep;                              dxs[8]  = nop; es[8]  = Z;
    fds[9]  = i_ins(5'b00101, 5'd6, 5'd5);          dxs[9]  = lw5; es[9]  = LU;
    fds[10] = i_ins(5'b00101, 5'd5, 5'd7);          dxs[10] = lw5; es[10] = Z;
    for (int i = 0; i < 11; i++) begin
      drive(fds[i], dxs[i], 1'b0, 1'b0, es[i]);
      @(negedge clock);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin errors++; $display("FAIL load_use case %0d: got %b want %b", i, obs, want); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] fds[4], dxs[4];
    logic        bts[4];
    logic [10:0] es[4];
    fds[0] = add_dep; dxs[0] = lw5;   bts[0] = 1'b1; es[0] = FL;
    fds[1] = nop;     dxs[1] = nop;   bts[1] = 1'b1; es[1] = FL;
    fds[2] = nop;     dxs[2] = mul_i; bts[2] = 1'b1; es[2] = FL;
    fds[3] = nop;     dxs[3] = nop;   bts[3] = 1'b0; es[3] = Z;
    for (int i = 0; i < 4; i++) begin
      drive(fds[i], dxs[i], bts[i], 1'b0, es[i]);
      @(negedge clock);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin errors++; $display("FAIL flush case %0d: got %b want %b", i, obs, want); end
    end
  endtask

  task automatic test_mul();
    int n_stall = 0;
    int n_start = 0;
    for (int c = 0; c < 7; c++) begin
      if (c == 0)      drive(add_dep, mul_i, 1'b0, 1'b0, S_MUL);
      else if (c < 5)  drive(add_dep, mul_i, 1'b0, 1'b0, WT);
      else if (c == 5) drive(add_dep, mul_i, 1'b0, 1'b1, DONE);
      else             drive(nop, nop, 1'b0, 1'b0, Z);
      @(negedge clock);
      n_stall += int'(stall_pc);
      n_start += int'(md_start_mult);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin errors++; $display("FAIL mul cycle %0d: got %b want %b", c, obs, want); end
    end
    checks++;
    if (n_stall != 5) begin errors++; $display("FAIL mul_stall_len: got %0d want 5", n_stall); end
    checks++;
    if (n_start != 1) begin errors++; $display("FAIL mul_start_pulses: got %0d want 1", n_start); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] dxs[9];
    logic        rdys[9];
    logic [10:0] es[9];
    int          starts = 0;
    for (int i = 0; i < 9; i++) rdys[i] = 1'b0;
    dxs[0] = mul_i; es[0] = S_MUL;
    dxs[1] = mul_i; es[1] = WT;
    dxs[2] = mul_i; es[2] = WT;
    dxs[3] = mul_i; es[3] = DONE;  rdys[3] = 1'b1;
    dxs[4] = div_i; es[4] = S_DIV;
    dxs[5] = div_i; es[5] = WT;
    dxs[6] = div_i; es[6] = WT;
    dxs[7] = div_i; es[7] = DONE;  rdys[7] = 1'b1;
    dxs[8] = nop;   es[8] = Z;
    for (int i = 0; i < 9; i++) begin
      drive(nop, dxs[i], 1'b0, rdys[i], es[i]);
      @(negedge clock);
      starts += int'(md_start_mult) + int'(md_start_div);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin errors++; $display("FAIL b2b cycle %0d: got %b want %b", i, obs, want); end
    end
    checks++;
    if (starts != 2) begin errors++; $display("FAIL b2b_starts: got %0d want 2", starts); end
  endtask

  task automatic test_reset_mid_op();
    drive(nop, mul_i, 1'b0, 1'b0, S_MUL);
    @(negedge clock);
    want = exp_q.pop_front();
    checks++;
    if (obs !== want) begin errors++; $display("FAIL rst_mid start: got %b want %b", obs, want); end
    for (int c = 1; c < 3; c++) begin
      drive(nop, mul_i, 1'b0, 1'b0, WT);
      @(negedge clock);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin errors++; $display("FAIL rst_mid wait %0d: got %b want %b", c, obs, want); end
    end
    drive(nop, mul_i, 1'b0, 1'b0, WT);
    #1;
    want = exp_q.pop_front();
    checks++;
    if (obs !== want) begin errors++; $display("FAIL rst_mid wait 3: got %b want %b", obs, want); end
    reset_n = 1'b0;
    exp_q.push_back(Z);
    #1;
    want = exp_q.pop_front();
    checks++;
    if (obs !== want) begin errors++; $display("FAIL rst_mid async: got %b want %b", obs, want); end
    @(negedge clock);
    dx_insn = nop;
    reset_n = 1'b1;
    drive(nop, nop, 1'b0, 1'b1, Z);
    @(negedge clock);
    want = exp_q.pop_front();
    checks++;
    if (obs !== want) begin errors++; $display("FAIL rst_mid stray_ready: got %b want %b", obs, want); end
    drive(nop, mul_i, 1'b0, 1'b0, S_MUL);
    @(negedge clock);
    want = exp_q.pop_front();
    checks++;
    if (obs !== want) begin errors++; $display("FAIL rst_mid restart: got %b want %b", obs, want); end
    drive(nop, mul_i, 1'b0, 1'b1, DONE);
    @(negedge clock);
    want = exp_q.pop_front();
    checks++;
    if (obs !== want) begin errors++; $display("FAIL rst_mid done: got %b want %b", obs, want); end
  endtask

  task automatic test_timeout();
    for (int c = 0; c < 45; c++) begin
      if (c == 0)       drive(nop, div_i, 1'b0, 1'b0, S_DIV);
      else if (c <= 40) drive(nop, div_i, 1'b0, 1'b0, WT);
      else if (c == 41) drive(nop, div_i, 1'b0, 1'b0, DONE);
      else if (c == 42) drive(nop, nop, 1'b0, 1'b0, TO);
      else if (c == 43) drive(nop, nop, 1'b0, 1'b1, TO);
      else              drive(add_dep, lw5, 1'b0, 1'b0, LU | TO);
      @(negedge clock);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin errors++; $display("FAIL timeout cycle %0d: got %b want %b", c, obs, want); end
    end
    #1;
    reset_n = 1'b0;
    exp_q.push_back(Z);
    #1;
    want = exp_q.pop_front();
    checks++;
    if (obs !== want) begin errors++; $display("FAIL timeout_clear: got %b want %b", obs, want); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_flush();
    test_mul();
    test_back_to_back();
    test_reset_mid_op();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
